// File: rtl/lane_permute_pkg.sv
// Shared types and width helpers for the lane permutation sequencer.
// Widths are derived at elaboration time from SIZE and the column coefficients.
package lane_permute_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        REDUCE = 3'd2,
        READ   = 3'd3,
        WAIT   = 3'd4,
        WRITE  = 3'd5,
        DONE   = 3'd6
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned k = 0; k < 32; k++) begin
            if ((64'd1 << k) < 64'(v)) r = k + 1;
        end
        return r;
    endfunction

    function automatic int unsigned aw_of(input int unsigned size);
        return clog2(2 * size * size);
    endfunction

    // Never zero, so that SIZE=1 still yields legal vector widths.
    function automatic int unsigned tw_of(input int unsigned size, input int unsigned a,
                                          input int unsigned b);
        int unsigned w;
        w = clog2((a + b) * (size - 1) + 1);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int unsigned cw_of(input int unsigned size);
        int unsigned w;
        w = clog2(size);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/lane_permute_sequencer_reducer.sv
// Iterative modulo-SIZE reducer: subtracts SIZE once per cycle after a load.
// ready rises in the cycle whose subtraction lands below SIZE, so dwell is max(1, t/SIZE).
module iter_mod_reducer
    import lane_permute_pkg::*;
#(
    parameter int unsigned SIZE = 5,
    parameter int unsigned TW   = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] t_in,
    output logic [TW-1:0] tmod,
    output logic          ready
);

    logic [TW-1:0] r;
    logic          ge_size;

    always_comb begin
        ge_size = 32'(r) >= SIZE;
        ready   = 32'(r) < 2 * SIZE;
        tmod    = ge_size ? TW'(32'(r) - SIZE) : r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
        end else if (load) begin
            r <= t_in;
        end else if (ge_size) begin
            r <= TW'(32'(r) - SIZE);
        end
    end

endmodule

// File: rtl/lane_permute_sequencer.sv
// Ping-pong permutation pass controller: lane (i,j) of one bank moves to
// (j, (A*i + B*j) mod SIZE) of the other bank, repeated for NROUNDS rounds.
module lane_permute_sequencer
    import lane_permute_pkg::*;
#(
    parameter int unsigned SIZE    = 5,
    parameter int unsigned LANE_W  = 64,
    parameter int unsigned A       = 2,
    parameter int unsigned B       = 3,
    parameter int unsigned NROUNDS = 1,
    parameter int unsigned AW      = aw_of(SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              final_bank,
    output logic              mem_rd,
    output logic [AW-1:0]     mem_raddr,
    input  logic [LANE_W-1:0] mem_rdata,
    output logic              mem_wr,
    output logic [AW-1:0]     mem_waddr,
    output logic [LANE_W-1:0] mem_wdata
);

    localparam int unsigned TW    = tw_of(SIZE, A, B);
    localparam int unsigned CW    = cw_of(SIZE);
    localparam int unsigned PLANE = SIZE * SIZE;

    state_t        state, state_n;
    logic [CW-1:0] i, i_n, j, j_n;
    logic [5:0]    round, round_n;
    logic          bank, bank_n, dst_bank;
    logic          fb_n;
    logic [TW-1:0] t_addr, red_tmod, tmod_q;
    logic          red_load, red_ready;

    assign t_addr   = TW'(A * 32'(i) + B * 32'(j));
    assign red_load = (state == ADDR);
    assign dst_bank = ~bank;

    iter_mod_reducer #(
        .SIZE(SIZE),
        .TW  (TW)
    ) u_reduce (
        .clk  (clk),
        .rst  (rst),
        .load (red_load),
        .t_in (t_addr),
        .tmod (red_tmod),
        .ready(red_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            i          <= '0;
            j          <= '0;
            round      <= '0;
            bank       <= 1'b0;
            final_bank <= 1'b0;
            tmod_q     <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= state_n;
            i          <= i_n;
            j          <= j_n;
            round      <= round_n;
            bank       <= bank_n;
            final_bank <= fb_n;
            if (state == REDUCE && red_ready) tmod_q <= red_tmod;
            if (state == WAIT) mem_wdata <= mem_rdata;
        end
    end

    always_comb begin
        state_n = state;
        i_n     = i;
        j_n     = j;
        round_n = round;
        bank_n  = bank;
        fb_n    = final_bank;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = ADDR;
                    i_n     = '0;
                    j_n     = '0;
                    round_n = '0;
                    bank_n  = 1'b0;
                end
            end
            ADDR:   state_n = REDUCE;
            REDUCE: if (red_ready) state_n = READ;
            READ:   state_n = WAIT;
            WAIT:   state_n = WRITE;
            WRITE: begin
                state_n = ADDR;
                if (32'(j) < SIZE - 1) begin
                    j_n = j + 1'b1;
                end else begin
                    j_n = '0;
                    if (32'(i) < SIZE - 1) begin
                        i_n = i + 1'b1;
                    end else begin
                        // End of a pass: the freshly written bank becomes the source.
                        i_n     = '0;
                        bank_n  = ~bank;
                        round_n = round + 1'b1;
                        if (32'(round) == NROUNDS - 1) begin
                            fb_n    = ~bank;
                            state_n = DONE;
                        end
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE) && (state != DONE);
        done      = (state == DONE);
        mem_rd    = (state == READ);
        mem_wr    = (state == WRITE);
        mem_raddr = '0;
        mem_waddr = '0;
        if (mem_rd) mem_raddr = AW'(32'(bank) * PLANE + 32'(i) * SIZE + 32'(j));
        if (mem_wr) mem_waddr = AW'(32'(dst_bank) * PLANE + 32'(j) * SIZE + 32'(tmod_q));
    end

endmodule

// File: tb/tb_lane_permute_sequencer.sv
// Scoreboard bench: expected reads/writes are queued at stimulus time and
// popped by negedge monitors whenever a DUT strobes its memory port.
module tb_lane_permute_sequencer;

    localparam int N  = 5;
    localparam int PL = 25;

    typedef struct packed {
        logic [5:0]  a;
        logic [63:0] d;
    } wexp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start0, busy0, done0, fb0, rd0, wr0;
    logic [5:0]  raddr0, waddr0;
    logic [63:0] rdata0 = '0, wdata0;
    logic        start1, busy1, done1, fb1, rd1, wr1;
    logic [5:0]  raddr1, waddr1;
    logic [63:0] rdata1 = '0, wdata1;

    lane_permute_sequencer #(
        .SIZE(5), .LANE_W(64), .A(2), .B(3), .NROUNDS(1)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .final_bank(fb0), .mem_rd(rd0), .mem_raddr(raddr0), .mem_rdata(rdata0),
        .mem_wr(wr0), .mem_waddr(waddr0), .mem_wdata(wdata0)
    );

    lane_permute_sequencer #(
        .SIZE(5), .LANE_W(64), .A(2), .B(3), .NROUNDS(2)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .final_bank(fb1), .mem_rd(rd1), .mem_raddr(raddr1), .mem_rdata(rdata1),
        .mem_wr(wr1), .mem_waddr(waddr1), .mem_wdata(wdata1)
    );

    logic [63:0] mem0 [0:49];
    logic [63:0] mem1 [0:49];

    always @(posedge clk) begin
        if (rd0) rdata0 <= mem0[raddr0];
        if (wr0) mem0[waddr0] = wdata0;
        if (rd1) rdata1 <= mem1[raddr1];
        if (wr1) mem1[waddr1] = wdata1;
    end

    wexp_t      wq0[$], wq1[$];
    logic [5:0] rq0[$], rq1[$];
    logic [5:0] wlog0[$];
    int         wtim0[$];
    int         errors = 0, checks = 0;
    int         cyc = 0, wcnt0 = 0, dcnt0 = 0, dcnt1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic extra(input string nm, input logic [5:0] addr);
        checks++;
        errors++;
        $display("FAIL %s: got access at %0d, want none", nm, addr);
    endtask

    always @(negedge clk) begin
        wexp_t      w;
        logic [5:0] a;
        if (rd0) begin
            if (rq0.size() == 0) extra("rd0_extra", raddr0);
            else begin a = rq0.pop_front(); chk("rd0_addr", raddr0, a); end
        end
        if (wr0) begin
            wcnt0++;
            wlog0.push_back(waddr0);
            wtim0.push_back(cyc);
            if (wq0.size() == 0) extra("wr0_extra", waddr0);
            else begin
                w = wq0.pop_front();
                chk("wr0_addr", waddr0, w.a);
                chk("wr0_data", wdata0, w.d);
            end
        end
        if (rd1) begin
            if (rq1.size() == 0) extra("rd1_extra", raddr1);
            else begin a = rq1.pop_front(); chk("rd1_addr", raddr1, a); end
        end
        if (wr1) begin
            if (wq1.size() == 0) extra("wr1_extra", waddr1);
            else begin
                w = wq1.pop_front();
                chk("wr1_addr", waddr1, w.a);
                chk("wr1_data", wdata1, w.d);
            end
        end
        if (done0) dcnt0++;
        if (done1) dcnt1++;
    end

    // Queue the reads/writes of nr passes from the current memory image; returns cycle total.
    task automatic expect_run(input int d, input int nr, output int total);
        logic [63:0] m [0:49];
        total = 0;
        for (int k = 0; k < 50; k++) m[k] = (d == 0) ? mem0[k] : mem1[k];
        for (int r = 0; r < nr; r++) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    int    t, src, dst, b;
                    wexp_t w;
                    b   = r % 2;
                    t   = 2 * i + 3 * j;
                    src = b * PL + i * N + j;
                    dst = (1 - b) * PL + j * N + t % N;
                    w.a = 6'(dst);
                    w.d = m[src];
                    m[dst] = m[src];
                    if (d == 0) begin rq0.push_back(6'(src)); wq0.push_back(w); end
                    else begin rq1.push_back(6'(src)); wq1.push_back(w); end
                    total += 4 + (((t / N) > 1) ? (t / N) : 1);
                end
            end
        end
    endtask

    task automatic pulse_start(input int d);
        @(negedge clk);
        if (d == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int d, output int c);
        int n;
        n = 0;
        while (((d == 0) ? done0 : done1) !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk((d == 0) ? "done0_seen" : "done1_seen", (d == 0) ? done0 : done1, 1);
        c = cyc;
    endtask

    task automatic check_bank1(input int base);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk("bank1_lane", mem0[PL + j * N + (2 * i + 3 * j) % N], 64'(base + i * N + j));
    endtask

    initial begin
        int c0, c1, s, k, n, d0, wsave;
        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        for (int a = 0; a < 50; a++) begin
            mem0[a] = (a < PL) ? 64'(a) : 64'hA5A5_0000 + 64'(a);
            mem1[a] = 64'(1000 + a);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_busy0", busy0, 0);
        chk("rst_done0", done0, 0);
        chk("rst_rd0", rd0, 0);
        chk("rst_wr0", wr0, 0);
        chk("rst_fb0", fb0, 0);
        chk("rst_raddr0", raddr0, 0);
        chk("rst_waddr0", waddr0, 0);
        chk("rst_wdata0", wdata0, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_fb1", fb1, 0);

        // single default pass
        wlog0.delete();
        wtim0.delete();
        d0 = dcnt0;
        expect_run(0, 1, s);
        pulse_start(0);
        c0 = cyc;
        chk("busy0_after_start", busy0, 1);
        wait_done(0, c1);
        chk("pass_cycles", c1 - c0, s);
        chk("pass_busy_in_done", busy0, 0);
        chk("pass_final_bank", fb0, 1);
        @(negedge clk);
        chk("pass_done_one_cycle", done0, 0);
        chk("pass_done_count", dcnt0 - d0, 1);
        chk("waddr_i1_j0", wlog0[5], 27);
        chk("waddr_i0_j1", wlog0[1], 33);
        chk("waddr_i4_j4", wlog0[24], 45);
        chk("gap_i4_j4", wtim0[24] - wtim0[23], 8);
        chk("pass_wq_drained", wq0.size(), 0);
        check_bank1(0);

        // two rounds, ping-pong
        d0 = dcnt1;
        expect_run(1, 2, s);
        pulse_start(1);
        c0 = cyc;
        wait_done(1, c1);
        chk("r2_cycles", c1 - c0, s);
        chk("r2_final_bank", fb1, 0);
        repeat (4) @(negedge clk);
        chk("r2_done_count", dcnt1 - d0, 1);
        chk("r2_rq_drained", rq1.size(), 0);
        chk("r2_wq_drained", wq1.size(), 0);

        // reset during REDUCE of element (2,3)
        for (int a = 0; a < PL; a++) mem0[a] = 64'(500 + a);
        expect_run(0, 1, s);
        pulse_start(0);
        k = 0;
        n = 0;
        while (k < 13 && n < 1000) begin
            @(negedge clk);
            n++;
            if (wr0) k++;
        end
        chk("abort_reached_2_2", k, 13);
        @(negedge clk);
        @(negedge clk);
        wsave = wcnt0;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy0, 0);
        chk("abort_wr", wr0, 0);
        chk("abort_rd", rd0, 0);
        chk("abort_done", done0, 0);
        chk("abort_fb", fb0, 0);
        chk("abort_waddr", waddr0, 0);
        chk("abort_wdata", wdata0, 0);
        rst = 1'b0;
        rq0.delete();
        wq0.delete();
        repeat (8) @(negedge clk);
        chk("abort_no_write", wcnt0 - wsave, 0);
        for (int a = 0; a < PL; a++) mem0[a] = 64'(700 + a);
        expect_run(0, 1, s);
        pulse_start(0);
        c0 = cyc;
        wait_done(0, c1);
        chk("fresh_cycles", c1 - c0, s);
        chk("fresh_final_bank", fb0, 1);
        @(negedge clk);
        chk("fresh_wq_drained", wq0.size(), 0);
        check_bank1(700);

        // start held high across a whole pass and its DONE cycle
        d0 = dcnt0;
        expect_run(0, 1, s);
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        c0 = cyc;
        chk("held_busy", busy0, 1);
        wait_done(0, c1);
        chk("held_cycles", c1 - c0, s);
        chk("held_busy_in_done", busy0, 0);
        expect_run(0, 1, s);
        @(negedge clk);
        chk("held_idle_done", done0, 0);
        chk("held_idle_busy", busy0, 0);
        @(negedge clk);
        chk("held_reaccept_busy", busy0, 1);
        start0 = 1'b0;
        c0 = cyc;
        wait_done(0, c1);
        chk("held_second_cycles", c1 - c0, s);
        repeat (3) @(negedge clk);
        chk("held_done_count", dcnt0 - d0, 2);
        chk("held_rq_drained", rq0.size(), 0);
        chk("held_wq_drained", wq0.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
